// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command parser: FSM states, drop causes and
// the ACK/NAK response bytes used when UART_CMD_ACK_EN is defined.
package uart_cmd_parser_pkg;

    typedef enum logic [2:0] {
        StHunt,
        StGetAddr,
        StGetLen,
        StGetData,
        StGetChk,
        StCommit,
        StError,
        StWaitAck
    } state_e;

    localparam logic [1:0] ErrChk     = 2'd0;
    localparam logic [1:0] ErrLen     = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;
    localparam logic [1:0] ErrLine    = 2'd3;

    localparam logic [7:0] AckByte = 8'h06;
    localparam logic [7:0] NakByte = 8'h15;

    function automatic logic len_valid(input logic [7:0] len, input logic [7:0] max_len);
        return (len != 8'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/uart_cmd_parser_buf.sv
// Payload holding buffer: Depth x 8 register array, synchronous write, combinational read.
// Indices at or beyond Depth read as zero and ignore writes.
module uart_cmd_buf #(
    parameter int unsigned Depth = 16,
    parameter int unsigned IdxW  = 5
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [IdxW-1:0] widx_i,
    input  logic [7:0]      wdata_i,
    input  logic [IdxW-1:0] ridx_i,
    output logic [7:0]      rdata_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [IdxW-1:0] DepthIdx = IdxW'(Depth);

    logic [7:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i && (widx_i < DepthIdx)) begin
            mem_q[widx_i[AddrW-1:0]] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = 8'h00;
        if (ridx_i < DepthIdx) begin
            rdata_o = mem_q[ridx_i[AddrW-1:0]];
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into SYNC/ADDR/LEN/DATA/CHK packets and replays verified payloads as
// register writes. Define UART_CMD_ACK_EN to add the tx_busy/ack_transmit/ack_byte handshake.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       recv_error,
    output logic       reg_we,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [1:0] err_code,
`ifdef UART_CMD_ACK_EN
    input  logic       tx_busy,
    output logic       ack_transmit,
    output logic [7:0] ack_byte,
`endif
    output logic       busy
);

    localparam int unsigned IdxW = $clog2(MAX_LEN + 1);
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmrW-1:0] TmrReload = TmrW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] MaxLen8 = 8'(MAX_LEN);

`ifdef UART_CMD_ACK_EN
    localparam state_e PostState = StWaitAck;
`else
    localparam state_e PostState = StHunt;
`endif

    state_e          state_q, state_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      acc_q, acc_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [TmrW-1:0] timer_q, timer_d;
    logic            reg_we_q, reg_we_d;
    logic [7:0]      reg_addr_q, reg_addr_d;
    logic [7:0]      reg_wdata_q, reg_wdata_d;
    logic            pkt_ok_q, pkt_ok_d;
    logic            pkt_err_q, pkt_err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            busy_q, busy_d;
`ifdef UART_CMD_ACK_EN
    logic            ack_transmit_q, ack_transmit_d;
    logic [7:0]      ack_byte_q, ack_byte_d;
`endif

    logic            buf_we;
    logic [7:0]      buf_rdata;
    logic            in_pkt;
    logic            err_go;
    logic [1:0]      err_sel;
    logic [IdxW-1:0] len_idx;
    logic [IdxW-1:0] idx_inc;

    assign len_idx = len_q[IdxW-1:0];
    assign idx_inc = idx_q + 1'b1;

    uart_cmd_buf #(
        .Depth (MAX_LEN),
        .IdxW  (IdxW)
    ) u_buf (
        .clk_i   (clk),
        .we_i    (buf_we),
        .widx_i  (idx_q),
        .wdata_i (rx_byte),
        .ridx_i  (idx_q),
        .rdata_o (buf_rdata)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        reg_we_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        pkt_ok_d    = 1'b0;
        pkt_err_d   = 1'b0;
        err_code_d  = err_code_q;
        buf_we      = 1'b0;
        err_go      = 1'b0;
        err_sel     = ErrChk;
        in_pkt      = (state_q == StGetAddr) || (state_q == StGetLen) ||
                      (state_q == StGetData) || (state_q == StGetChk);

        if (in_pkt) begin
            // recv_error beats a simultaneous byte strobe; the byte is lost.
            if (recv_error) begin
                err_go  = 1'b1;
                err_sel = ErrLine;
            end else if (received) begin
                timer_d = TmrReload;
                unique case (state_q)
                    StGetAddr: begin
                        addr_d  = rx_byte;
                        acc_d   = rx_byte;
                        state_d = StGetLen;
                    end
                    StGetLen: begin
                        if (!len_valid(rx_byte, MaxLen8)) begin
                            err_go  = 1'b1;
                            err_sel = ErrLen;
                        end else begin
                            len_d   = rx_byte;
                            acc_d   = acc_q ^ rx_byte;
                            idx_d   = '0;
                            state_d = StGetData;
                        end
                    end
                    StGetData: begin
                        buf_we = 1'b1;
                        acc_d  = acc_q ^ rx_byte;
                        if (idx_inc == len_idx) begin
                            idx_d   = '0;
                            state_d = StGetChk;
                        end else begin
                            idx_d = idx_inc;
                        end
                    end
                    StGetChk: begin
                        if (rx_byte == acc_q) begin
                            // Issue the first write now so the burst starts next cycle.
                            reg_we_d    = 1'b1;
                            reg_addr_d  = addr_q;
                            reg_wdata_d = buf_rdata;
                            idx_d       = idx_inc;
                            state_d     = StCommit;
                        end else begin
                            err_go  = 1'b1;
                            err_sel = ErrChk;
                        end
                    end
                    default: ;
                endcase
            end else if (timer_q == '0) begin
                err_go  = 1'b1;
                err_sel = ErrTimeout;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end else begin
            case (state_q)
                StHunt: begin
                    if (received && !recv_error && (rx_byte == SYNC_BYTE)) begin
                        timer_d = TmrReload;
                        state_d = StGetAddr;
                    end
                end
                StCommit: begin
                    if (idx_q != len_idx) begin
                        reg_we_d    = 1'b1;
                        reg_addr_d  = addr_q + 8'(idx_q);
                        reg_wdata_d = buf_rdata;
                        idx_d       = idx_inc;
                    end else begin
                        pkt_ok_d = 1'b1;
                        idx_d    = '0;
                        state_d  = PostState;
                    end
                end
                StError: begin
                    state_d = PostState;
                end
`ifdef UART_CMD_ACK_EN
                StWaitAck: begin
                    if (!tx_busy) begin
                        state_d = StHunt;
                    end
                end
`endif
                default: begin
                    state_d = StHunt;
                end
            endcase
        end

        if (err_go) begin
            state_d    = StError;
            pkt_err_d  = 1'b1;
            err_code_d = err_sel;
        end

        busy_d = (state_d != StHunt);
    end

`ifdef UART_CMD_ACK_EN
    always_comb begin
        ack_byte_d     = ack_byte_q;
        ack_transmit_d = 1'b0;
        if (pkt_ok_d) begin
            ack_byte_d = AckByte;
        end else if (pkt_err_d) begin
            ack_byte_d = NakByte;
        end
        if ((state_q == StWaitAck) && !tx_busy) begin
            ack_transmit_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StHunt;
            addr_q         <= 8'h00;
            len_q          <= 8'h00;
            acc_q          <= 8'h00;
            idx_q          <= '0;
            timer_q        <= '0;
            reg_we_q       <= 1'b0;
            reg_addr_q     <= 8'h00;
            reg_wdata_q    <= 8'h00;
            pkt_ok_q       <= 1'b0;
            pkt_err_q      <= 1'b0;
            err_code_q     <= 2'd0;
            busy_q         <= 1'b0;
`ifdef UART_CMD_ACK_EN
            ack_transmit_q <= 1'b0;
            ack_byte_q     <= 8'h00;
`endif
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            acc_q          <= acc_d;
            idx_q          <= idx_d;
            timer_q        <= timer_d;
            reg_we_q       <= reg_we_d;
            reg_addr_q     <= reg_addr_d;
            reg_wdata_q    <= reg_wdata_d;
            pkt_ok_q       <= pkt_ok_d;
            pkt_err_q      <= pkt_err_d;
            err_code_q     <= err_code_d;
            busy_q         <= busy_d;
`ifdef UART_CMD_ACK_EN
            ack_transmit_q <= ack_transmit_d;
            ack_byte_q     <= ack_byte_d;
`endif
        end
    end

    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign pkt_ok    = pkt_ok_q;
    assign pkt_err   = pkt_err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;
`ifdef UART_CMD_ACK_EN
    assign ack_transmit = ack_transmit_q;
    assign ack_byte     = ack_byte_q;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected writes/events are queued as bytes are
// sent and popped by a negedge monitor as the parser produces them.
module tb_uart_cmd_parser;

    localparam int unsigned MaxLen  = 16;
    localparam int unsigned Timeout = 300;
    localparam int unsigned Gap     = 24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       received = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       recv_error = 1'b0;
    logic       reg_we;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;
`ifdef UART_CMD_ACK_EN
    logic       tx_busy = 1'b0;
    logic       ack_transmit;
    logic [7:0] ack_byte;
`endif

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .MAX_LEN        (MaxLen),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .received     (received),
        .rx_byte      (rx_byte),
        .recv_error   (recv_error),
        .reg_we       (reg_we),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .pkt_ok       (pkt_ok),
        .pkt_err      (pkt_err),
        .err_code     (err_code),
`ifdef UART_CMD_ACK_EN
        .tx_busy      (tx_busy),
        .ack_transmit (ack_transmit),
        .ack_byte     (ack_byte),
`endif
        .busy         (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_wr[$];
    int          exp_ev[$];   // 4 = pkt_ok, 0..3 = pkt_err with that code
    int          exp_lat[$];
    logic [7:0]  pay [256];
    int          cyc = 0;
    int          last_rx = 0;
    bit          prev_we = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, away from the parser's active edge.
    initial begin
        logic [15:0] w;
        int ev;
        int act;
        forever begin
            @(negedge clk);
            if (received) last_rx = cyc;
            if (reg_we) begin
                if (!prev_we) check("first_we_latency", cyc - last_rx, 1);
                if (exp_wr.size() == 0) begin
                    check("unexpected_we", reg_we, 0);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", reg_addr, w[15:8]);
                    check("wr_data", reg_wdata, w[7:0]);
                end
            end
            prev_we = reg_we;
            if (pkt_ok || pkt_err) begin
                act = pkt_ok ? 4 : int'(err_code);
                if (pkt_ok && pkt_err) act = 7;
                if (exp_ev.size() == 0) begin
                    check("unexpected_event", act, 99);
                end else begin
                    ev = exp_ev.pop_front();
                    check("event", act, ev);
                    if (pkt_ok && exp_lat.size() != 0) begin
                        check("ok_latency", cyc - last_rx, exp_lat.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        repeat (Gap) @(posedge clk);
        #1 received = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1 received = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] addr, input int len, input bit bad);
        logic [7:0] chk;
        chk = addr ^ 8'(len);
        for (int i = 0; i < len; i++) chk ^= pay[i];
        if (bad) begin
            chk ^= 8'h07;
            exp_ev.push_back(0);
        end else begin
            for (int i = 0; i < len; i++) exp_wr.push_back({addr + 8'(i), pay[i]});
            exp_ev.push_back(4);
            exp_lat.push_back(len + 1);
        end
        send_byte(8'hA5);
        #2 check("busy_after_sync", busy, 1);
        send_byte(addr);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) send_byte(pay[i]);
        send_byte(chk);
    endtask

    task automatic pulse_line_error();
        @(posedge clk);
        #1 recv_error = 1'b1;
        @(posedge clk);
        #1 recv_error = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_reg_we", reg_we, 0);
        check("rst_pkt_ok", pkt_ok, 0);
        check("rst_pkt_err", pkt_err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_busy", busy, 0);
        check("rst_reg_addr", reg_addr, 0);
        rst_n = 1'b1;

        // Basic good packet, then the same with a bad checksum.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_pkt(8'h10, 3, 1'b0);
        send_pkt(8'h10, 3, 1'b1);

        // Length zero and length above MAX_LEN.
        exp_ev.push_back(1);
        send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00);
        exp_ev.push_back(1);
        send_byte(8'hA5); send_byte(8'h40); send_byte(8'h11);

        // Address wrap from 0xFE to 0x00.
        pay[0] = 8'hAA; pay[1] = 8'hBB;
        send_pkt(8'hFE, 2, 1'b0);

        // Timeout mid-payload, then recovery with a good packet.
        exp_ev.push_back(2);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03); send_byte(8'h11);
        repeat (Timeout + 20) @(posedge clk);
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_pkt(8'h10, 3, 1'b0);

        // Line error mid-payload; line error with simultaneous byte; line error in HUNT.
        exp_ev.push_back(3);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03); send_byte(8'h11);
        pulse_line_error();
        exp_ev.push_back(3);
        send_byte(8'hA5); send_byte(8'h10);
        repeat (Gap) @(posedge clk);
        #1 received = 1'b1; rx_byte = 8'h03; recv_error = 1'b1;
        @(posedge clk);
        #1 received = 1'b0; recv_error = 1'b0;
        pulse_line_error();

        // SYNC value as address and payload is plain data.
        pay[0] = 8'hA5; pay[1] = 8'h01;
        send_pkt(8'hA5, 2, 1'b0);

        // Full-length packet across the address wrap, then random packets.
        for (int i = 0; i < 16; i++) pay[i] = 8'(8'h30 + i);
        send_pkt(8'hF8, 16, 1'b0);
        for (int k = 0; k < 4; k++) begin
            int len;
            len = int'($urandom_range(1, MaxLen));
            for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
            send_pkt(8'($urandom), len, 1'b0);
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 16; i++) pay[i] = 8'(8'hC0 + i);
        send_pkt(8'h20, 16, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("midrst_reg_we", reg_we, 0);
        check("midrst_busy", busy, 0);
        exp_wr.delete();
        exp_ev.delete();
        exp_lat.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        pay[0] = 8'h5A;
        send_pkt(8'h77, 1, 1'b0);

`ifdef UART_CMD_ACK_EN
        begin
            int seen;
            seen = 0;
            tx_busy = 1'b1;
            exp_ev.push_back(3);
            send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03); send_byte(8'h11);
            pulse_line_error();
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (ack_transmit) seen++;
            end
            check("ack_while_tx_busy", seen, 0);
            #1 tx_busy = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (ack_transmit) begin
                    seen++;
                    check("ack_byte_nak", ack_byte, 8'h15);
                end
            end
            check("ack_pulse_count", seen, 1);
        end
`endif

        repeat (40) @(posedge clk);
        #1;
        check("writes_drained", exp_wr.size(), 0);
        check("events_drained", exp_ev.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
